// File: rtl/demux_grant_scheduler.sv
// demux_grant_scheduler: shares a 1-to-4 active-low demux among four
// requesters. Each grant is limited to HOLD_MAX cycles and is followed
// by a one-cycle guard gap.
// Ports: iClk, iRst_n (async, active-low), iReq[3:0], iC (serial bit),
//        oS1/oS0 (select), oZ0..oZ3 (active-low outputs), oGnt[3:0], oBusy.
// Macro DEMUX_RR_EN: when defined, round-robin arbitration; when
// undefined, fixed priority with channel 0 highest.
module demux_grant_scheduler #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [3:0] iReq,
    input  logic       iC,
    output logic       oS1,
    output logic       oS0,
    output logic       oZ0,
    output logic       oZ1,
    output logic       oZ2,
    output logic       oZ3,
    output logic [3:0] oGnt,
    output logic       oBusy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLD_MAX);

    state_t           state;
    state_t           stateNext;
    logic [1:0]       sel;
    logic [1:0]       selNext;
    logic [1:0]       ptr;
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [3:0]       zVec;

    // Scan from the farthest offset down so the nearest requester
    // at or after ptr wins.
    always_comb begin
        winner = ptr;
        idx    = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (iReq[idx]) begin
                winner = idx;
            end
        end
    end

    always_comb begin
        stateNext = state;
        selNext   = sel;
        cntNext   = cnt;
        unique case (state)
            IDLE: begin
                if (|iReq) begin
                    selNext   = winner;
                    cntNext   = CNT_W'(1);
                    stateNext = GRANT;
                end
            end
            GRANT: begin
                if (!iReq[sel] || cnt == HoldMax) begin
                    stateNext = GAP;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            GAP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
            sel   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            sel   <= selNext;
            cnt   <= cntNext;
        end
    end

`ifdef DEMUX_RR_EN
    // Rotate priority past the channel that was just served.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ptr <= 2'd0;
        end else if (state == GAP) begin
            ptr <= sel + 2'd1;
        end
    end
`else
    assign ptr = 2'd0;
`endif

    // Outputs derive from registered state, so an async reset clears
    // the grant and forces the demux outputs high immediately.
    always_comb begin
        zVec = 4'b1111;
        if (state == GRANT) begin
            zVec[sel] = iC;
        end
    end

    assign oGnt  = (state == GRANT) ? (4'b0001 << sel) : 4'b0000;
    assign oBusy = (state != IDLE);
    assign oS1   = sel[1];
    assign oS0   = sel[0];
    assign oZ0   = zVec[0];
    assign oZ1   = zVec[1];
    assign oZ2   = zVec[2];
    assign oZ3   = zVec[3];

endmodule

// File: doc/demux_grant_scheduler.md
# demux_grant_scheduler

Round-robin scheduler that shares the 1-to-4 active-low demultiplexer path among four requesters. It arbitrates requests, drives the demux select lines, and routes the serial bit `iC` to the granted channel. It bounds each grant to a maximum hold time and inserts a one-cycle guard gap between grants. It sits between the channel request logic and the 1-to-4 demux output stage.

## Interface
- `HOLD_MAX`, 8: maximum cycles a grant may last; legal range 1..255.
- `CNT_W`, 8: hold-counter width; must satisfy 2^CNT_W > HOLD_MAX.
- `iClk`  in  1  system clock; all state updates on the rising edge.
- `iRst_n`  in  1  asynchronous, active-low reset.
- `iReq`  in  4  per-channel request, active-high, level-held by the requester.
- `iC`  in  1  serial data bit to route to the granted channel.
- `oS1`, `oS0`  out  1 each  registered demux select; `{oS1,oS0}` = granted channel index.
- `oZ0`..`oZ3`  out  1 each  demux outputs, active-low.
  - In GRANT, `oZ[sel]` = `iC`.
  - All other `oZ` bits = 1.
  - Outside GRANT, all `oZ` = 1.
- `oGnt`  out  4  registered one-hot grant, active-high; all 0 outside GRANT.
- `oBusy`  out  1  high in GRANT and GAP.

## Operation
- States: IDLE, GRANT, GAP.
- Internal registers:
  - `sel` (2 bits): current winner.
  - `ptr` (2 bits): highest-priority channel for the next arbitration.
  - `cnt` (CNT_W bits): grant-cycle counter.
- IDLE:
  - If `iReq` = 0, stay in IDLE.
  - Otherwise pick the winner: the first set bit scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - Load `sel`, set `cnt` = 1, go to GRANT.
- GRANT:
  - `oGnt[sel]` = 1; `{oS1,oS0}` = `sel`.
  - `oZ` follows the demux rule combinationally from `iC` and the registered `sel`.
  - If `iReq[sel]` = 0 or `cnt` == HOLD_MAX, go to GAP.
  - Otherwise `cnt` increments and the block stays in GRANT.
- GAP:
  - Exactly one cycle; `oGnt` = 0; all `oZ` = 1.
  - `ptr` ← `sel` + 1 (wraps 3 → 0).
  - Go to IDLE.
- `{oS1,oS0}` keep their last value in IDLE and GAP. Selects never change while any `oGnt` bit is high.
- Requests from other channels during GRANT are ignored until the next IDLE arbitration.
- A requester that still holds `iReq` after a HOLD_MAX timeout stays eligible. It competes again with its priority rotated behind the others.
- `iReq` edges mid-cycle have no effect until the next rising clock edge. No synchronisation is performed inside the block.

## Timing
- Reset (asynchronous assert, synchronous release on the first `iClk` edge after `iRst_n` rises):
  - state = IDLE; `ptr` = 0; `sel` = 0; `cnt` = 0.
  - `oGnt` = 0000; `oS1` = `oS0` = 0; `oZ0`..`oZ3` = 1; `oBusy` = 0.
- Reset asserted mid-grant drops `oGnt` and forces all `oZ` high immediately, without waiting for a clock edge.
- Grant latency: `iReq` sampled high in IDLE at edge k → `oGnt`/select valid after edge k.
- Grant duration: N cycles, where N = the number of edges in GRANT with `iReq[sel]` high, capped at HOLD_MAX.
- Minimum spacing between consecutive grants: GAP (1 cycle) + IDLE (1 cycle) = 2 cycles with all `oZ` high.
- HOLD_MAX = 1 gives single-cycle grants.
- `cnt` never exceeds HOLD_MAX; no wrap.

## Configuration
- `DEMUX_RR_EN`:
  - Defined: round-robin arbitration as above; `ptr` rotates after every GRANT.
  - Undefined: fixed priority with channel 0 highest and channel 3 lowest. `ptr` is held at 0 and never updated; its register logic may be removed.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold `iRst_n` = 0 with `iReq` = 1111 → `oGnt` = 0000, `oZ` = 1111, `{oS1,oS0}` = 00, `oBusy` = 0. Release reset → first grant is channel 0.
- Single request: `iReq` = 0100 held for 3 cycles then dropped, `iC` toggling →
  - `oGnt` = 0100 for 3 cycles; `{oS1,oS0}` = 10.
  - `oZ2` follows `iC`; `oZ0`, `oZ1`, `oZ3` = 1.
  - Then 1 GAP cycle with `oZ` = 1111.
- Timeout: HOLD_MAX = 4, `iReq` = 0001 held forever → repeated 4-cycle grants to channel 0 separated by 2 idle cycles.
- Round-robin (`DEMUX_RR_EN` defined): `iReq` = 1111 held, HOLD_MAX = 2 → grant order 0, 1, 2, 3, 0.
- Fixed priority (`DEMUX_RR_EN` undefined): `iReq` = 1010 held, HOLD_MAX = 2 → every grant goes to channel 1; channel 3 is never granted.
- Mid-grant reset: assert `iRst_n` = 0 during the second cycle of a channel-3 grant → `oGnt` = 0000 and `oZ3` = 1 within the same cycle, without a clock edge. After release, arbitration restarts with `ptr` = 0.
